// File: rtl/restoring_div_unit_pkg.sv
// Shared types and constants for the restoring divider (package div_pkg).
package div_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    CALC   = 3'd2,
    FIXUP  = 3'd3,
    FINISH = 3'd4
  } state_e;

  // Quotient reported on divide-by-zero: all ones in the low w bits.
  function automatic logic [63:0] all_ones(input int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/restoring_div_unit_if.sv
// Handshake and operand/result bundle for restoring_div_unit.
// Optional signed mode adds signed_op when RESTORING_DIV_SIGNED_EN is defined.
interface restoring_div_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef RESTORING_DIV_SIGNED_EN
  logic             signed_op;
`endif
  logic             idle;
  logic             busy;
  logic             finish;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
`ifdef RESTORING_DIV_SIGNED_EN
    output signed_op,
`endif
    output start, dividend, divisor,
    input  idle, busy, finish, div_by_zero, quotient, remainder
  );

  modport slave (
`ifdef RESTORING_DIV_SIGNED_EN
    input  signed_op,
`endif
    input  start, dividend, divisor,
    output idle, busy, finish, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/restoring_div_unit_step.sv
// One combinational restoring-division step (module div_step).
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   p_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   p_o,
  output logic             q_o
);

  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] p_diff;
  logic           unused_p_msb;

  // The partial remainder stays below the divisor, so its top bit is shifted out.
  assign unused_p_msb = p_i[WIDTH];

  // Shift in the next dividend bit and subtract when the divisor fits.
  always_comb begin
    p_shift = {p_i[WIDTH-1:0], bit_i};
    p_diff  = p_shift - {1'b0, divisor_i};
    q_o     = (p_shift >= {1'b0, divisor_i});
    p_o     = q_o ? p_diff : p_shift;
  end

endmodule

// File: rtl/restoring_div_unit.sv
// Sequential restoring divider: one quotient bit per CALC cycle.
// Optional signed mode (FIXUP state, signed_op input) under RESTORING_DIV_SIGNED_EN.
module restoring_div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                  CLK,
  input logic                  reset,
  restoring_div_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] Q_ONES = WIDTH'(all_ones(WIDTH));

  state_e           state_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, q_q, quot_q, rem_q;
  logic [WIDTH:0]   p_q;
  logic [CNT_W-1:0] idx_q;
  logic             idle_q, busy_q, fin_q, dbz_q;
`ifdef RESTORING_DIV_SIGNED_EN
  logic             sgn_q;
`endif

  logic [WIDTH-1:0] dvd_mag_c, dvs_mag_c;
  logic [WIDTH:0]   p_d;
  logic             qbit_d;

  // Operand magnitudes fed to the step (identity in unsigned mode).
  always_comb begin
    dvd_mag_c = dvd_q;
    dvs_mag_c = dvs_q;
`ifdef RESTORING_DIV_SIGNED_EN
    if (sgn_q && dvd_q[WIDTH-1]) dvd_mag_c = WIDTH'(-dvd_q);
    if (sgn_q && dvs_q[WIDTH-1]) dvs_mag_c = WIDTH'(-dvs_q);
`endif
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i      (p_q),
    .bit_i    (dvd_mag_c[idx_q]),
    .divisor_i(dvs_mag_c),
    .p_o      (p_d),
    .q_o      (qbit_d)
  );

  // Control FSM, bit counter, datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      p_q     <= '0;
      idx_q   <= CNT_W'(WIDTH - 1);
      quot_q  <= '0;
      rem_q   <= '0;
      idle_q  <= 1'b1;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef RESTORING_DIV_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dvd_q   <= bus.dividend;
            dvs_q   <= bus.divisor;
            dbz_q   <= 1'b0;
            idle_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CHECK;
`ifdef RESTORING_DIV_SIGNED_EN
            sgn_q   <= bus.signed_op;
`endif
          end
        end
        CHECK: begin
          if (dvs_q == '0) begin
            quot_q  <= Q_ONES;
            rem_q   <= dvd_q;
            dbz_q   <= 1'b1;
            busy_q  <= 1'b0;
            fin_q   <= 1'b1;
            state_q <= FINISH;
          end else begin
            p_q     <= '0;
            q_q     <= '0;
            idx_q   <= CNT_W'(WIDTH - 1);
            state_q <= CALC;
          end
        end
        CALC: begin
          p_q        <= p_d;
          q_q[idx_q] <= qbit_d;
          if (idx_q == '0) begin
`ifdef RESTORING_DIV_SIGNED_EN
            state_q <= FIXUP;
`else
            quot_q  <= {q_q[WIDTH-1:1], qbit_d};
            rem_q   <= p_d[WIDTH-1:0];
            busy_q  <= 1'b0;
            fin_q   <= 1'b1;
            state_q <= FINISH;
`endif
          end else begin
            idx_q <= idx_q - CNT_W'(1);
          end
        end
`ifdef RESTORING_DIV_SIGNED_EN
        FIXUP: begin
          quot_q  <= (sgn_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1])) ? WIDTH'(-q_q) : q_q;
          rem_q   <= (sgn_q && dvd_q[WIDTH-1]) ? WIDTH'(-p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
          busy_q  <= 1'b0;
          fin_q   <= 1'b1;
          state_q <= FINISH;
        end
`endif
        FINISH: begin
          fin_q   <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          fin_q   <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.idle        = idle_q;
  assign bus.busy        = busy_q;
  assign bus.finish      = fin_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;

endmodule

// File: tb/tb_restoring_div_unit.sv
// Scoreboard bench for restoring_div_unit (WIDTH=8 and WIDTH=16 instances).
module tb_restoring_div_unit;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    string       nm;
  } exp_t;

`ifdef RESTORING_DIV_SIGNED_EN
  localparam int L8  = 11;
  localparam int L16 = 19;
`else
  localparam int L8  = 10;
  localparam int L16 = 18;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q8[$];
  exp_t q16[$];
  logic unused_sg;

  always #5 clk = ~clk;

  restoring_div_unit_if #(.WIDTH(8))  b8 ();
  restoring_div_unit_if #(.WIDTH(16)) b16 ();

  restoring_div_unit #(.WIDTH(8))  u8  (.CLK(clk), .reset(rst), .bus(b8));
  restoring_div_unit #(.WIDTH(16)) u16 (.CLK(clk), .reset(rst), .bus(b16));

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitor for the 8-bit unit: compare each finish against the queue head.
  initial forever begin
    @(negedge clk);
    if (b8.finish === 1'b1) begin
      if (q8.size() == 0) check("unexpected_finish8", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        check({e.nm, "_quot"}, 32'(b8.quotient), 32'(e.q));
        check({e.nm, "_rem"},  32'(b8.remainder), 32'(e.r));
        check({e.nm, "_dbz"},  32'(b8.div_by_zero), 32'(e.dbz));
      end
    end
  end

  // Monitor for the 16-bit unit.
  initial forever begin
    @(negedge clk);
    if (b16.finish === 1'b1) begin
      if (q16.size() == 0) check("unexpected_finish16", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q16.pop_front();
        check({e.nm, "_quot"}, 32'(b16.quotient), 32'(e.q));
        check({e.nm, "_rem"},  32'(b16.remainder), 32'(e.r));
        check({e.nm, "_dbz"},  32'(b16.div_by_zero), 32'(e.dbz));
      end
    end
  end

  // One 8-bit operation: push expectation, start, then check timing and busy window.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sg,
                     input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                     input int elat, input string nm);
    exp_t e;
    int   lat;
    logic busy_ok;
    e.q = 16'(eq); e.r = 16'(er); e.dbz = edbz; e.nm = nm;
    q8.push_back(e);
    unused_sg = sg;
    @(negedge clk);
    b8.start = 1'b1; b8.dividend = a; b8.divisor = b;
`ifdef RESTORING_DIV_SIGNED_EN
    b8.signed_op = sg;
`endif
    @(posedge clk); #1;
    b8.start = 1'b0; b8.dividend = ~a; b8.divisor = 8'h00;
    lat = 0; busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (b8.finish) begin lat = k; break; end
      if (!b8.busy || b8.idle) busy_ok = 1'b0;
    end
    check({nm, "_latency"}, 32'(lat), 32'(elat));
    check({nm, "_busy"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    check({nm, "_pulse_idle"}, {30'd0, b8.finish, b8.idle}, 32'b01);
  endtask

  initial begin
    exp_t e;
    int   fcnt;
    int   lat;
    b8.start = 1'b0; b8.dividend = '0; b8.divisor = '0;
    b16.start = 1'b0; b16.dividend = '0; b16.divisor = '0;
`ifdef RESTORING_DIV_SIGNED_EN
    b8.signed_op = 1'b0; b16.signed_op = 1'b0;
`endif
    unused_sg = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {26'd0, b8.idle, b8.busy, b8.finish, b8.div_by_zero,
                          (b8.quotient != 0), (b8.remainder != 0)}, 32'b100000);

    op8(8'd100, 8'd7,   1'b0, 8'd14,  8'd2,  1'b0, L8, "u100_7");
    op8(8'd55,  8'd0,   1'b0, 8'd255, 8'd55, 1'b1, 2,  "u55_0");
    repeat (3) @(negedge clk);
    check("dbz_held", 32'(b8.div_by_zero), 32'd1);
    op8(8'd8,   8'd2,   1'b0, 8'd4,   8'd0,  1'b0, L8, "u8_2");
    op8(8'd255, 8'd1,   1'b0, 8'd255, 8'd0,  1'b0, L8, "u255_1");
    op8(8'd3,   8'd200, 1'b0, 8'd0,   8'd3,  1'b0, L8, "u3_200");
    op8(8'd255, 8'd255, 1'b0, 8'd1,   8'd0,  1'b0, L8, "u255_255");
    op8(8'd0,   8'd9,   1'b0, 8'd0,   8'd0,  1'b0, L8, "u0_9");

    // start held high through the whole operation: exactly one result.
    e.q = 16'd22; e.r = 16'd2; e.dbz = 1'b0; e.nm = "held200_9";
    q8.push_back(e);
    @(negedge clk);
    b8.start = 1'b1; b8.dividend = 8'd200; b8.divisor = 8'd9;
    @(posedge clk); #1;
    b8.dividend = 8'd1; b8.divisor = 8'd1;
    fcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (b8.finish) begin fcnt++; b8.start = 1'b0; break; end
    end
    check("held_finish_count", 32'(fcnt), 32'd1);
    @(negedge clk);
    check("held_idle_return", 32'(b8.idle), 32'd1);
    @(negedge clk);
    check("held_no_second_op", {30'd0, b8.idle, b8.busy}, 32'b10);

    // 16-bit instance.
    e.q = 16'd487; e.r = 16'd99; e.dbz = 1'b0; e.nm = "w16_60000_123";
    q16.push_back(e);
    @(negedge clk);
    b16.start = 1'b1; b16.dividend = 16'd60000; b16.divisor = 16'd123;
    @(posedge clk); #1;
    b16.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (b16.finish) begin lat = k; break; end
    end
    check("w16_latency", 32'(lat), 32'(L16));

    // Reset in the middle of an operation.
    @(negedge clk);
    b8.start = 1'b1; b8.dividend = 8'd100; b8.divisor = 8'd7;
    @(posedge clk); #1;
    b8.start = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midop_reset", {26'd0, b8.idle, b8.busy, b8.finish, b8.div_by_zero,
                          (b8.quotient != 0), (b8.remainder != 0)}, 32'b100000);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("midop_reset_stays_idle", 32'(b8.idle), 32'd1);

`ifdef RESTORING_DIV_SIGNED_EN
    op8(8'h9C, 8'd7,  1'b1, 8'hF2, 8'hFE, 1'b0, 11, "s_m100_7");
    op8(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 11, "s_m128_m1");
`endif

    repeat (3) @(negedge clk);
    check("queue8_drained",  32'(q8.size()),  32'd0);
    check("queue16_drained", 32'(q16.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
